shape_cmd_sequencer: RTL
========================

# shape_cmd_sequencer

Upstream command front-end for the shape processor's control SFR. Buffers shape/operation update commands from a valid/ready source in a small FIFO, drives the SFR `write`/`read` strobes, and reads back the register after every write. The SFR silently drops illegal updates. The sequencer therefore reports per command whether the update took effect, plus the resulting register contents.

## Interface
- `DEPTH`, 4: command FIFO entries, power of two, ≥2.
- `TAG_W`, 4: width of the command tag echoed in the response.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command FIFO not full.
- `cmd_shape`  in  2  requested shape; `2'b11` means keep current.
- `cmd_operation`  in  6  requested operation; `6'h3F` means keep current.
- `cmd_tag`  in  TAG_W  opaque tag.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_accepted`  out  1  readback matches the resolved request.
- `rsp_error`  out  1  SFR `error` was seen high during WRITE or CHECK.
- `rsp_shape`  out  2  shape read back in CHECK.
- `rsp_operation`  out  6  operation read back in CHECK.
- `rsp_tag`  out  TAG_W  tag of the command.
- `write`  out  1  SFR write strobe.
- `write_data`  out  32  SFR write word.
- `read`  out  1  SFR read strobe.
- `read_data`  in  32  SFR read word: `[17:16]` shape, `[5:0]` operation.
- `error`  in  1  SFR error flag.

## Operation
- **FIFO push:** on `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`; there is no bypass, so a pop in the same cycle does not free a slot for a push.
  - A push and a pop in the same cycle leave the count unchanged.
- **States:** IDLE, SNAP, WRITE, CHECK, RESP.
- **IDLE:** if the FIFO is non-empty, pop the head into the current-command register and go to SNAP.
- **SNAP:**
  - Assert `read`.
  - Capture `read_data[17:16]` and `read_data[5:0]` as the snapshot.
  - Go to WRITE.
- **WRITE:**
  - Assert `write`.
  - `write_data` carries `cmd_shape` in `[17:16]` and `cmd_operation` in `[5:0]`; all other bits are 0.
  - Go to CHECK.
- **CHECK:**
  - Assert `read`.
  - Capture the readback.
  - Resolve the expected values:
    - expected shape = snapshot shape if `cmd_shape == 2'b11`, else `cmd_shape`;
    - expected operation = snapshot operation if `cmd_operation == 6'h3F`, else `cmd_operation`.
  - `accepted` = both readback fields equal the expected values.
  - Go to RESP.
- **RESP:**
  - Hold `rsp_valid` and all `rsp_*` stable until `rsp_ready`.
  - On the handshake: go to SNAP (popping the next command) if the FIFO is non-empty, else go to IDLE.
- `error` is ORed into a sticky flag during WRITE and CHECK. The flag is cleared when a new command is popped.
- `write`, `read` and `write_data` are 0 in every state not listed above.
- **Reset values:**
  - state IDLE, FIFO empty;
  - `cmd_ready = 1`;
  - all other outputs 0.
- **Reset mid-operation:** the command in flight and all FIFO contents are discarded. No partial strobe is issued after `rst_n` falls.

## Timing
- `write`, `read`, `write_data`, `rsp_*` and `cmd_ready` are registered or decoded from registered state only; there is no combinational path from any input.
- **Minimum latency:**
  - cycle 0: push;
  - cycle 1: IDLE pop;
  - cycle 2: SNAP;
  - cycle 3: WRITE;
  - cycle 4: CHECK;
  - cycle 5: `rsp_valid` high.
- **Back-to-back throughput:** one command per 4 cycles when `rsp_ready` is tied high.
- **Bus timing:** the SFR updates on the clock edge ending WRITE. `read_data` is combinational from the SFR, so CHECK sees the post-write value.

## Configuration
- **`SHAPE_CMD_SEQ_STATS_EN` defined:** adds two outputs, `stat_accepted` (16 bits) and `stat_rejected` (16 bits).
  - Each increments on a response handshake, according to `rsp_accepted`.
  - Both saturate at `16'hFFFF`.
  - Both reset to 0.
- **Undefined:** the two ports and their counters do not exist.

## Structure
- **Package `shape_pkg`:**
  - shape and operation field bit positions;
  - keep codes `2'b11` and `6'h3F`;
  - the `shape_cmd_t` struct (shape, operation, tag);
  - the state enum.
- **Sub-module `shape_cmd_fifo`:**
  - synchronous FIFO of `shape_cmd_t`, parameter `DEPTH`;
  - ports: push/pop/full/empty;
  - pointers one bit wider than `log2(DEPTH)`, so full and empty are distinguished by the extra bit.

## Test plan
- **Legal update:** after reset (SFR at shape 01, operation 00), send shape `2'b10`, operation `6'h20` → `rsp_accepted = 1`, `rsp_shape = 10`, `rsp_operation = 20`, response 5 cycles after the push.
- **Illegal combination:** from reset, send shape `2'b01`, operation `6'h20` → `rsp_accepted = 0`, `rsp_shape = 01`, `rsp_operation = 00`.
- **Keep code:** from reset, send shape `2'b11`, operation `6'h01` → `write_data = 32'h0003_0001`, `rsp_accepted = 1`, `rsp_shape = 01`, `rsp_operation = 01`.
- **Backpressure:** `DEPTH = 4`, `rsp_ready` held low, continuous `cmd_valid` → exactly 5 commands accepted (1 in flight, 4 buffered), after which `cmd_ready = 0`. Releasing `rsp_ready` returns responses in tag order, one every 4 cycles.
- **Reset mid-operation:** assert `rst_n` low during WRITE → `write`, `read`, `rsp_valid` all 0 immediately. After release, `cmd_ready = 1` and no response arrives for the discarded command.
- **`SHAPE_CMD_SEQ_STATS_EN`:** after the first two scenarios → `stat_accepted = 1`, `stat_rejected = 1`.

Source files
------------

// File: rtl/shape_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shape_pkg
// Description : Shared types and constants for the shape command sequencer.
//               These are the SFR field positions, the keep codes, the
//               command record and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package shape_pkg;

  // SFR field positions
  localparam int SHAPE_LSB = 16;
  localparam int SHAPE_MSB = 17;
  localparam int OP_LSB    = 0;
  localparam int OP_MSB    = 5;

  // Codes meaning "leave this field as it is"
  localparam logic [1:0] SHAPE_KEEP = 2'b11;
  localparam logic [5:0] OP_KEEP    = 6'h3F;

  // Tag width stored in the command FIFO
  localparam int CMD_TAG_W = 4;

  typedef struct packed {
    logic [1:0]           shape;
    logic [5:0]           operation;
    logic [CMD_TAG_W-1:0] tag;
  } shape_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNAP  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_e;

  // Build an SFR word holding only the shape and operation fields
  function automatic logic [31:0] pack_sfr_word(input logic [1:0] shape,
                                                input logic [5:0] operation);
    logic [31:0] w;
    w                    = '0;
    w[SHAPE_MSB:SHAPE_LSB] = shape;
    w[OP_MSB:OP_LSB]       = operation;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shape_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : shape_cmd_sequencer_if
// Description : Command, response and SFR bus signals of the shape command
//               sequencer. The slave modport is the sequencer's view.
//               SHAPE_CMD_SEQ_STATS_EN adds the two statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface shape_cmd_sequencer_if #(
  parameter int TAG_W = 4
);
  // command stream
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_shape;
  logic [5:0]       cmd_operation;
  logic [TAG_W-1:0] cmd_tag;
  // response stream
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_accepted;
  logic             rsp_error;
  logic [1:0]       rsp_shape;
  logic [5:0]       rsp_operation;
  logic [TAG_W-1:0] rsp_tag;
  // SFR bus
  logic             write;
  logic [31:0]      write_data;
  logic             read;
  logic [31:0]      read_data;
  logic             error;
`ifdef SHAPE_CMD_SEQ_STATS_EN
  logic [15:0]      stat_accepted;
  logic [15:0]      stat_rejected;
`endif

  modport slave (
    input  cmd_valid, cmd_shape, cmd_operation, cmd_tag,
    output cmd_ready,
    output rsp_valid, rsp_accepted, rsp_error, rsp_shape, rsp_operation, rsp_tag,
    input  rsp_ready,
    output write, write_data, read,
    input  read_data, error
`ifdef SHAPE_CMD_SEQ_STATS_EN
    , output stat_accepted, stat_rejected
`endif
  );

  modport master (
    output cmd_valid, cmd_shape, cmd_operation, cmd_tag,
    input  cmd_ready,
    input  rsp_valid, rsp_accepted, rsp_error, rsp_shape, rsp_operation, rsp_tag,
    output rsp_ready,
    input  write, write_data, read,
    output read_data, error
`ifdef SHAPE_CMD_SEQ_STATS_EN
    , input stat_accepted, stat_rejected
`endif
  );

endinterface
`default_nettype wire

// File: rtl/shape_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : shape_cmd_fifo
// Description : Synchronous FIFO of shape_cmd_t. Pointers carry one extra
//               wrap bit so that full and empty are told apart without a
//               separate counter. Push when full and pop when empty are
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module shape_cmd_fifo
  import shape_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  shape_cmd_t push_data,
  input  logic       pop,
  output shape_cmd_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  shape_cmd_t  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers on accepted push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; reset discards the contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; no reset needed since the pointers define validity
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/shape_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shape_cmd_sequencer
// Description : Buffers shape/operation update commands and applies each to
//               the control SFR as snapshot-read, write, check-read. It then
//               reports whether the SFR took the update. Optional macro
//               SHAPE_CMD_SEQ_STATS_EN adds saturating accepted/rejected
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module shape_cmd_sequencer
  import shape_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = CMD_TAG_W
) (
  input logic                 clk,
  input logic                 rst_n,
  shape_cmd_sequencer_if.slave bus
);

  seq_state_e state_q, state_d;
  shape_cmd_t cur_q, cur_d;
  shape_cmd_t fifo_in, fifo_head;
  logic [1:0] snap_shape_q, snap_shape_d;
  logic [5:0] snap_op_q, snap_op_d;
  logic [1:0] rb_shape_q, rb_shape_d;
  logic [5:0] rb_op_q, rb_op_d;
  logic       acc_q, acc_d;
  logic       err_q, err_d;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0] rd_shape, exp_shape;
  logic [5:0] rd_op, exp_op;
  logic       unused_read_bits;

  // The FIFO stores CMD_TAG_W tag bits; TAG_W is expected to match it
  assign fifo_in   = '{shape: bus.cmd_shape, operation: bus.cmd_operation,
                       tag: CMD_TAG_W'(bus.cmd_tag)};
  assign fifo_push = bus.cmd_valid && !fifo_full;

  shape_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_shape         = bus.read_data[SHAPE_MSB:SHAPE_LSB];
  assign rd_op            = bus.read_data[OP_MSB:OP_LSB];
  assign unused_read_bits = ^{bus.read_data[31:18], bus.read_data[15:6]};

  // Keep codes resolve against the value seen before the write
  assign exp_shape = (cur_q.shape == SHAPE_KEEP)  ? snap_shape_q : cur_q.shape;
  assign exp_op    = (cur_q.operation == OP_KEEP) ? snap_op_q    : cur_q.operation;

  // Next-state and datapath capture for the snapshot/write/check sequence
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    snap_shape_d = snap_shape_q;
    snap_op_d    = snap_op_q;
    rb_shape_d   = rb_shape_q;
    rb_op_d      = rb_op_q;
    acc_d        = acc_q;
    err_d        = err_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          err_d    = 1'b0;
          state_d  = ST_SNAP;
        end
      end
      ST_SNAP: begin
        snap_shape_d = rd_shape;
        snap_op_d    = rd_op;
        state_d      = ST_WRITE;
      end
      ST_WRITE: begin
        err_d   = err_q | bus.error;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        err_d      = err_q | bus.error;
        rb_shape_d = rd_shape;
        rb_op_d    = rd_op;
        acc_d      = (rd_shape == exp_shape) && (rd_op == exp_op);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_head;
            err_d    = 1'b0;
            state_d  = ST_SNAP;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      snap_shape_q <= '0;
      snap_op_q    <= '0;
      rb_shape_q   <= '0;
      rb_op_q      <= '0;
      acc_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      snap_shape_q <= snap_shape_d;
      snap_op_q    <= snap_op_d;
      rb_shape_q   <= rb_shape_d;
      rb_op_q      <= rb_op_d;
      acc_q        <= acc_d;
      err_q        <= err_d;
    end
  end

  // All outputs decode from registered state only
  assign bus.cmd_ready     = !fifo_full;
  assign bus.read          = (state_q == ST_SNAP) || (state_q == ST_CHECK);
  assign bus.write         = (state_q == ST_WRITE);
  assign bus.write_data    = (state_q == ST_WRITE) ?
                             pack_sfr_word(cur_q.shape, cur_q.operation) : 32'h0;
  assign bus.rsp_valid     = (state_q == ST_RESP);
  assign bus.rsp_accepted  = acc_q;
  assign bus.rsp_error     = err_q;
  assign bus.rsp_shape     = rb_shape_q;
  assign bus.rsp_operation = rb_op_q;
  assign bus.rsp_tag       = TAG_W'(cur_q.tag);

`ifdef SHAPE_CMD_SEQ_STATS_EN
  logic [15:0] stat_acc_q, stat_acc_d;
  logic [15:0] stat_rej_q, stat_rej_d;

  // Saturating per-outcome counters, stepped on each response handshake
  always_comb begin
    stat_acc_d = stat_acc_q;
    stat_rej_d = stat_rej_q;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (acc_q) begin
        if (stat_acc_q != 16'hFFFF) stat_acc_d = stat_acc_q + 16'd1;
      end else begin
        if (stat_rej_q != 16'hFFFF) stat_rej_d = stat_rej_q + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_acc_q <= '0;
      stat_rej_q <= '0;
    end else begin
      stat_acc_q <= stat_acc_d;
      stat_rej_q <= stat_rej_d;
    end
  end

  assign bus.stat_accepted = stat_acc_q;
  assign bus.stat_rejected = stat_rej_q;
`endif

endmodule
`default_nettype wire
